identity_check_sequencer: RTL

//  Drives stored stimulus vectors into two instances of a fuzzed design: the
//  pre-synthesis reference and the synthesized netlist. It waits a fixed

---
 rtl/identity_check_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/identity_check_sequencer.sv
// Replays stored stimulus into a reference and a synthesized DUT, waits a fixed
// settle time, then compares both output buses and keeps mismatch statistics.
module identity_check_sequencer #(
  parameter int IN_W       = 64,
  parameter int OUT_W      = 166,
  parameter int NUM_VEC    = 21,
  parameter int ADDR_W     = 5,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  y_ref,
  input  logic [OUT_W-1:0]  y_dut,
  output logic              busy,
  output logic              cmp_valid,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [OUT_W-1:0]  fail_diff
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [SW-1:0]     settle;
  logic              mis;

  // Default to mismatch so an unknown compare result is never treated as equal.
  always_comb begin
    mis = 1'b1;
    if (y_ref == y_dut) mis = 1'b0;
  end

  assign vec_addr  = idx;
  assign busy      = (state == S_FETCH) || (state == S_APPLY) ||
                     (state == S_SETTLE) || (state == S_CHECK);
  assign cmp_valid = (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign pass      = done && (mismatch_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      settle         <= '0;
      dut_in         <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      fail_diff      <= '0;
    end else if (abort && busy) begin
      // Partial statistics stay visible until the next start.
      state  <= S_IDLE;
      dut_in <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx            <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            fail_diff      <= '0;
            state          <= S_FETCH;
          end
        end
        S_FETCH: state <= S_APPLY;
        S_APPLY: begin
          dut_in <= vec_data;
          settle <= SW'(SETTLE_CYC - 1);
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle == '0) state <= S_CHECK;
          else              settle <= settle - 1'b1;
        end
        S_CHECK: begin
          if (mis) begin
            if (mismatch_cnt == '0) begin
              first_fail_idx <= idx;
              fail_diff      <= y_ref ^ y_dut;
            end
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
          end
          if (idx == ADDR_W'(NUM_VEC - 1)) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
